// File: rtl/tlb_pipe.sv
// Dual-search-port TLB with a registered lookup pipeline, a combinational read port,
// a wired-aware random replacement counter and a one-entry-per-cycle ASID invalidate sweep.

module tlb_lookup #(
    parameter int TLBNUM = 16,
    parameter int IW     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_i,
    input  logic [18:0]              vpn2_i,
    input  logic                     odd_i,
    input  logic [7:0]               asid_i,
    input  logic [TLBNUM-1:0]        e_tab_i,
    input  logic [TLBNUM-1:0]        g_tab_i,
    input  logic [TLBNUM-1:0][18:0]  vpn2_tab_i,
    input  logic [TLBNUM-1:0][7:0]   asid_tab_i,
    input  logic [TLBNUM-1:0][19:0]  pfn0_tab_i,
    input  logic [TLBNUM-1:0][19:0]  pfn1_tab_i,
    input  logic [TLBNUM-1:0][2:0]   c0_tab_i,
    input  logic [TLBNUM-1:0][2:0]   c1_tab_i,
    input  logic [TLBNUM-1:0]        d0_tab_i,
    input  logic [TLBNUM-1:0]        d1_tab_i,
    input  logic [TLBNUM-1:0]        v0_tab_i,
    input  logic [TLBNUM-1:0]        v1_tab_i,
    output logic                     rvalid_o,
    output logic                     found_o,
    output logic                     multi_o,
    output logic [IW-1:0]            index_o,
    output logic [19:0]              pfn_o,
    output logic [2:0]               c_o,
    output logic                     d_o,
    output logic                     v_o
);
    logic [TLBNUM-1:0] hit;
    logic [IW-1:0]     hit_idx;
    logic              rvalid_q, found_q, multi_q, d_q, v_q;
    logic [IW-1:0]     index_q;
    logic [19:0]       pfn_q;
    logic [2:0]        c_q;

    always_comb begin
        hit = '0;
        for (int i = 0; i < TLBNUM; i++)
            hit[i] = e_tab_i[i] && (vpn2_tab_i[i] == vpn2_i) && (g_tab_i[i] || asid_tab_i[i] == asid_i);
    end

    // Scan downward so the lowest matching index wins.
    always_comb begin
        hit_idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--)
            if (hit[i]) hit_idx = IW'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            found_q  <= 1'b0;
            multi_q  <= 1'b0;
            index_q  <= '0;
            pfn_q    <= '0;
            c_q      <= '0;
            d_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            rvalid_q <= req_i;
            if (req_i) begin
                found_q <= |hit;
                multi_q <= |(hit & (hit - TLBNUM'(1)));
                if (|hit) begin
                    index_q <= hit_idx;
                    pfn_q   <= odd_i ? pfn1_tab_i[hit_idx] : pfn0_tab_i[hit_idx];
                    c_q     <= odd_i ? c1_tab_i[hit_idx]   : c0_tab_i[hit_idx];
                    d_q     <= odd_i ? d1_tab_i[hit_idx]   : d0_tab_i[hit_idx];
                    v_q     <= odd_i ? v1_tab_i[hit_idx]   : v0_tab_i[hit_idx];
                end else begin
                    index_q <= '0;
                    pfn_q   <= '0;
                    c_q     <= '0;
                    d_q     <= 1'b0;
                    v_q     <= 1'b0;
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign found_o  = found_q;
    assign multi_o  = multi_q;
    assign index_o  = index_q;
    assign pfn_o    = pfn_q;
    assign c_o      = c_q;
    assign d_o      = d_q;
    assign v_o      = v_q;
endmodule

module tlb_pipe #(
    parameter int TLBNUM = 16,
    localparam int IW    = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s0_req,
    input  logic [18:0]   s0_vpn2,
    input  logic          s0_odd_page,
    input  logic [7:0]    s0_asid,
    output logic          s0_rvalid,
    output logic          s0_found,
    output logic          s0_multi,
    output logic [IW-1:0] s0_index,
    output logic [19:0]   s0_pfn,
    output logic [2:0]    s0_c,
    output logic          s0_d,
    output logic          s0_v,
    input  logic          s1_req,
    input  logic [18:0]   s1_vpn2,
    input  logic          s1_odd_page,
    input  logic [7:0]    s1_asid,
    output logic          s1_rvalid,
    output logic          s1_found,
    output logic          s1_multi,
    output logic [IW-1:0] s1_index,
    output logic [19:0]   s1_pfn,
    output logic [2:0]    s1_c,
    output logic          s1_d,
    output logic          s1_v,
    input  logic          we,
    input  logic          w_random,
    input  logic [IW-1:0] w_index,
    input  logic [18:0]   w_vpn2,
    input  logic [7:0]    w_asid,
    input  logic          w_g,
    input  logic [19:0]   w_pfn0,
    input  logic [19:0]   w_pfn1,
    input  logic [2:0]    w_c0,
    input  logic [2:0]    w_c1,
    input  logic          w_d0,
    input  logic          w_d1,
    input  logic          w_v0,
    input  logic          w_v1,
    input  logic [IW-1:0] r_index,
    output logic          r_e,
    output logic [18:0]   r_vpn2,
    output logic [7:0]    r_asid,
    output logic          r_g,
    output logic [19:0]   r_pfn0,
    output logic [19:0]   r_pfn1,
    output logic [2:0]    r_c0,
    output logic [2:0]    r_c1,
    output logic          r_d0,
    output logic          r_d1,
    output logic          r_v0,
    output logic          r_v1,
    input  logic [IW-1:0] wired,
    output logic [IW-1:0] rand_index,
    input  logic          inv_req,
    input  logic          inv_all,
    input  logic [7:0]    inv_asid,
    output logic          inv_busy,
    output logic          inv_done
);
    localparam logic [IW-1:0] LAST = IW'(TLBNUM - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} inv_state_e;

    logic [TLBNUM-1:0]       e_q, e_d, g_q, d0_q, d1_q, v0_q, v1_q;
    logic [TLBNUM-1:0][18:0] vpn2_q;
    logic [TLBNUM-1:0][7:0]  asid_q;
    logic [TLBNUM-1:0][19:0] pfn0_q, pfn1_q;
    logic [TLBNUM-1:0][2:0]  c0_q, c1_q;
    logic [IW-1:0]           rand_q, rand_d, ptr_q, ptr_d, w_tgt;
    inv_state_e              state_q, state_d;
    logic                    inv_all_q, inv_all_d, sweep_clr;
    logic [7:0]              inv_asid_q, inv_asid_d;

    assign w_tgt = w_random ? rand_q : w_index;

    always_ff @(posedge clk) begin
        if (we) begin
            vpn2_q[w_tgt] <= w_vpn2;
            asid_q[w_tgt] <= w_asid;
            g_q[w_tgt]    <= w_g;
            pfn0_q[w_tgt] <= w_pfn0;
            pfn1_q[w_tgt] <= w_pfn1;
            c0_q[w_tgt]   <= w_c0;
            c1_q[w_tgt]   <= w_c1;
            d0_q[w_tgt]   <= w_d0;
            d1_q[w_tgt]   <= w_d1;
            v0_q[w_tgt]   <= w_v0;
            v1_q[w_tgt]   <= w_v1;
        end
    end

    // Write is applied after the sweep clear so a same-entry write leaves E set.
    always_comb begin
        e_d = e_q;
        if (sweep_clr) e_d[ptr_q] = 1'b0;
        if (we)        e_d[w_tgt] = 1'b1;
    end

    always_comb begin
        if (wired >= LAST || rand_q <= wired) rand_d = LAST;
        else                                  rand_d = rand_q - IW'(1);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        inv_all_d  = inv_all_q;
        inv_asid_d = inv_asid_q;
        sweep_clr  = 1'b0;
        case (state_q)
            IDLE: if (inv_req) begin
                inv_all_d  = inv_all;
                inv_asid_d = inv_asid;
                ptr_d      = '0;
                state_d    = SWEEP;
            end
            SWEEP: begin
                sweep_clr = e_q[ptr_q] &&
                            (inv_all_q || (asid_q[ptr_q] == inv_asid_q && !g_q[ptr_q]));
                ptr_d     = ptr_q + IW'(1);
                if (ptr_q == LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q        <= '0;
            rand_q     <= LAST;
            state_q    <= IDLE;
            ptr_q      <= '0;
            inv_all_q  <= 1'b0;
            inv_asid_q <= '0;
        end else begin
            e_q        <= e_d;
            rand_q     <= rand_d;
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            inv_all_q  <= inv_all_d;
            inv_asid_q <= inv_asid_d;
        end
    end

    assign rand_index = rand_q;
    assign inv_busy   = (state_q == SWEEP);
    assign inv_done   = (state_q == DONE);

    assign r_e    = e_q[r_index];
    assign r_vpn2 = vpn2_q[r_index];
    assign r_asid = asid_q[r_index];
    assign r_g    = g_q[r_index];
    assign r_pfn0 = pfn0_q[r_index];
    assign r_pfn1 = pfn1_q[r_index];
    assign r_c0   = c0_q[r_index];
    assign r_c1   = c1_q[r_index];
    assign r_d0   = d0_q[r_index];
    assign r_d1   = d1_q[r_index];
    assign r_v0   = v0_q[r_index];
    assign r_v1   = v1_q[r_index];

    logic [1:0]          s_req, s_odd, s_rvalid, s_found, s_multi, s_d, s_v;
    logic [1:0][18:0]    s_vpn2;
    logic [1:0][7:0]     s_asid;
    logic [1:0][IW-1:0]  s_index;
    logic [1:0][19:0]    s_pfn;
    logic [1:0][2:0]     s_c;

    assign s_req  = {s1_req, s0_req};
    assign s_odd  = {s1_odd_page, s0_odd_page};
    assign s_vpn2 = {s1_vpn2, s0_vpn2};
    assign s_asid = {s1_asid, s0_asid};

    for (genvar p = 0; p < 2; p++) begin : g_port
        tlb_lookup #(.TLBNUM(TLBNUM), .IW(IW)) u_lookup (
            .clk        (clk),
            .reset      (reset),
            .req_i      (s_req[p]),
            .vpn2_i     (s_vpn2[p]),
            .odd_i      (s_odd[p]),
            .asid_i     (s_asid[p]),
            .e_tab_i    (e_q),
            .g_tab_i    (g_q),
            .vpn2_tab_i (vpn2_q),
            .asid_tab_i (asid_q),
            .pfn0_tab_i (pfn0_q),
            .pfn1_tab_i (pfn1_q),
            .c0_tab_i   (c0_q),
            .c1_tab_i   (c1_q),
            .d0_tab_i   (d0_q),
            .d1_tab_i   (d1_q),
            .v0_tab_i   (v0_q),
            .v1_tab_i   (v1_q),
            .rvalid_o   (s_rvalid[p]),
            .found_o    (s_found[p]),
            .multi_o    (s_multi[p]),
            .index_o    (s_index[p]),
            .pfn_o      (s_pfn[p]),
            .c_o        (s_c[p]),
            .d_o        (s_d[p]),
            .v_o        (s_v[p])
        );
    end

    assign {s1_rvalid, s0_rvalid} = s_rvalid;
    assign {s1_found,  s0_found}  = s_found;
    assign {s1_multi,  s0_multi}  = s_multi;
    assign {s1_d,      s0_d}      = s_d;
    assign {s1_v,      s0_v}      = s_v;
    assign s0_index = s_index[0];
    assign s1_index = s_index[1];
    assign s0_pfn   = s_pfn[0];
    assign s1_pfn   = s_pfn[1];
    assign s0_c     = s_c[0];
    assign s1_c     = s_c[1];
endmodule

// File: doc/tlb_pipe.md
TLB_PIPE -- requirements
Module: tlb_pipe

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, entry count; power of two, 4..64; IW = log2(TLBNUM).
REQ-002 SHALL have clock `clk`, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have reset `reset`, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have search port 0 inputs: `s0_req` 1, `s0_vpn2` 19, `s0_odd_page` 1, `s0_asid` 8.
REQ-005 SHALL have search port 0 outputs: `s0_rvalid` 1, `s0_found` 1, `s0_multi` 1, `s0_index` IW, `s0_pfn` 20, `s0_c` 3, `s0_d` 1, `s0_v` 1.
REQ-006 SHALL have search port 1 with ports identical to port 0, prefixed `s1_`.
REQ-007 SHALL have write port inputs: `we` 1, `w_random` 1, `w_index` IW, `w_vpn2` 19, `w_asid` 8, `w_g` 1, `w_pfn0/1` 20, `w_c0/1` 3, `w_d0/1` 1, `w_v0/1` 1.
REQ-008 SHALL have read port: input `r_index` IW; outputs `r_e` 1 plus `r_vpn2`, `r_asid`, `r_g`, `r_pfn0/1`, `r_c0/1`, `r_d0/1`, `r_v0/1` (widths as write port).
REQ-009 SHALL have replacement ports: input `wired` IW (entries below it are never randomly chosen); output `rand_index` IW.
REQ-010 SHALL have invalidate ports: inputs `inv_req` 1, `inv_all` 1, `inv_asid` 8; outputs `inv_busy` 1, `inv_done` 1.

Function
REQ-011 SHALL keep a per-entry existence bit E; an entry matches only if E=1, vpn2 equal, and (asid equal or G=1).
REQ-012 SHALL register search results: `sN_req` high at edge k -> `sN_rvalid`=1 for exactly the cycle after edge k, with results of the lookup made at edge k.
REQ-013 SHALL drive `sN_index`, `sN_pfn`, `sN_c`, `sN_d`, `sN_v` to 0 on miss; on hit, select the odd (1) or even (0) half per `sN_odd_page`.
REQ-014 SHALL resolve multiple hits to the lowest matching index and set `sN_multi`=1; otherwise `sN_multi`=0.
REQ-015 SHALL hold result outputs stable while `sN_req`=0 (`sN_rvalid`=0).
REQ-016 SHALL write on `we`: target = `rand_index` if `w_random`=1, else `w_index`; all fields written and E set to 1.
REQ-017 SHALL return pre-write contents to a search or read made in the same cycle as a write to the same entry.
REQ-018 SHALL keep the read port combinational: `r_*` reflect the current contents of entry `r_index`, with `r_e`=E.
REQ-019 SHALL decrement `rand_index` every cycle; when `rand_index` <= `wired`, next value is TLBNUM-1; when `wired` >= TLBNUM-1, hold at TLBNUM-1.
REQ-020 SHALL implement invalidate FSM IDLE -> SWEEP -> DONE -> IDLE; `inv_req` in IDLE latches `inv_all`/`inv_asid` and enters SWEEP with pointer 0.
REQ-021 SHALL in SWEEP visit one entry per cycle at pointer p: clear E if `inv_all`=1 or (asid equal and G=0); p increments; after p=TLBNUM-1 -> DONE.
REQ-022 SHALL assert `inv_busy`=1 in SWEEP (exactly TLBNUM cycles) and `inv_done`=1 for the single DONE cycle; `inv_req` outside IDLE is ignored.
REQ-023 SHALL give `we` priority over the sweep when both target the same entry in one cycle (E ends 1); searches and writes remain legal during SWEEP.

Reset
REQ-024 SHALL on `reset`=1 clear all E bits, FSM -> IDLE, pointer 0, `rand_index`=TLBNUM-1, `sN_rvalid`/`sN_found`/`sN_multi`/`sN_index`/`sN_pfn`/`sN_c`/`sN_d`/`sN_v`=0, `inv_busy`=`inv_done`=0; other stored fields are undefined.
REQ-025 SHALL abort an in-progress sweep on reset with no `inv_done` pulse.

Verification
REQ-026 SHALL cover: after reset, search vpn2=0 asid=0 -> `rvalid`=1 next cycle, `found`=0, all result fields 0.
REQ-027 SHALL cover: write idx 5 {vpn2=0x12345, asid=3, g=0, pfn1=0xABCDE, v1=1}; search same vpn2/asid, odd=1 -> next cycle found=1, index=5, pfn=0xABCDE, v=1; with asid=4 -> found=0.
REQ-028 SHALL cover: the same vpn2 written to idx 2 and 9 with g=1 -> index=2, multi=1.
REQ-029 SHALL cover: TLBNUM=16, wired=4 -> `rand_index` sequence 15,14,...,4,15; `w_random` write lands at the displayed value.
REQ-030 SHALL cover: entries asid 3 (g=0), asid 3 (g=1), asid 7; inv_req asid=3 -> busy for 16 cycles, done 1 cycle; only the first is cleared; write to idx p at sweep time of p -> entry survives.
